// File: rtl/lab9_soc_pio_gen_if.sv
// rtl/lab9_soc_pio_gen_if.sv - Avalon-MM slave bus bundle for the PIO register file
interface lab9_soc_pio_gen_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/lab9_soc_pio_gen.sv
// rtl/lab9_soc_pio_gen.sv - Avalon-MM PIO: direction, synchronised input, edge capture, level IRQ
// Optional atomic OUTSET/OUTCLR writes enabled by macro PIO_GEN_SETCLR_EN.
module lab9_soc_pio_gen #(
   parameter int               WIDTH       = 16,
   parameter int               SYNC_STAGES = 2,
   parameter int               EDGE_TYPE   = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   lab9_soc_pio_gen_if.slave bus,
   input  logic [WIDTH-1:0]  in_port,
   output logic [WIDTH-1:0]  out_port,
   output logic [WIDTH-1:0]  oe,
   output logic              irq
);
   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_DIR    = 3'd1;
   localparam logic [2:0] A_MASK   = 3'd2;
   localparam logic [2:0] A_EDGE   = 3'd3;
   localparam logic [2:0] A_OUTSET = 3'd4;
   localparam logic [2:0] A_OUTCLR = 3'd5;

   logic [WIDTH-1:0]                  data_q, data_d;
   logic [WIDTH-1:0]                  dir_q, dir_d;
   logic [WIDTH-1:0]                  mask_q, mask_d;
   logic [WIDTH-1:0]                  edge_q, edge_d;
   logic [WIDTH-1:0]                  prev_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [31:0]                       rd_q, rd_d;
   logic [WIDTH-1:0]                  in_sync, edge_det, w1c, wd, pin_rd;
   logic                              wr;
   logic                              unused_wd;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign wd        = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;
   assign in_sync   = sync_q[SYNC_STAGES-1];
   assign pin_rd    = (dir_q & data_q) | (~dir_q & in_sync);

   // Detection runs on every bit regardless of direction.
   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_det = in_sync & ~prev_q;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_det = ~in_sync & prev_q;
      end else begin : g_any
         assign edge_det = in_sync ^ prev_q;
      end
   endgenerate

   always_comb begin
      data_d = data_q;
      dir_d  = dir_q;
      mask_d = mask_q;
      w1c    = '0;
      rd_d   = '0;
      if (wr) begin
         case (bus.address)
            A_DATA:   data_d = wd;
            A_DIR:    dir_d  = wd;
            A_MASK:   mask_d = wd;
            A_EDGE:   w1c    = wd;
`ifdef PIO_GEN_SETCLR_EN
            A_OUTSET: data_d = data_q | wd;
            A_OUTCLR: data_d = data_q & ~wd;
`endif
            default:  ;
         endcase
      end
      // A fresh edge outranks a clear arriving on the same clock.
      edge_d = (edge_q & ~w1c) | edge_det;
      case (bus.address)
         A_DATA:  rd_d[WIDTH-1:0] = pin_rd;
         A_DIR:   rd_d[WIDTH-1:0] = dir_q;
         A_MASK:  rd_d[WIDTH-1:0] = mask_q;
         A_EDGE:  rd_d[WIDTH-1:0] = edge_q;
         default: rd_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         dir_q  <= DIR_RESET;
         mask_q <= '0;
         edge_q <= '0;
         prev_q <= '0;
         sync_q <= '0;
         rd_q   <= '0;
      end else begin
         data_q    <= data_d;
         dir_q     <= dir_d;
         mask_q    <= mask_d;
         edge_q    <= edge_d;
         prev_q    <= in_sync;
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         rd_q      <= rd_d;
      end
   end

   assign bus.readdata = rd_q;
   assign out_port     = data_q;
   assign oe           = dir_q;
   assign irq          = |(edge_q & mask_q);
endmodule

// File: tb/tb_lab9_soc_pio_gen.sv
// tb/tb_lab9_soc_pio_gen.sv - self-checking bench for lab9_soc_pio_gen with a behavioural model
module tb_lab9_soc_pio_gen;
   localparam int          W  = 16;
   localparam int          S  = 2;
   localparam int          ET = 0;
   localparam logic [15:0] RV = 16'h5A00;
   localparam logic [15:0] DR = 16'h0000;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] in_port = '0;
   logic [15:0] out_port, oe;
   logic        irq;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] rp = '0;

   lab9_soc_pio_gen_if bus();

   lab9_soc_pio_gen #(
      .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(ET), .RESET_VALUE(RV), .DIR_RESET(DR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Model: pin samples kept as a history; the synchronised view is the sample
   // S clocks old, the previous view S+1 clocks old.
   logic [15:0] m_data, m_dir, m_mask, m_edge, m_w1c, m_sync, m_prev, m_det, m_wd;
   logic [31:0] m_rd;
   logic [15:0] samp [0:S];
   logic        m_valid = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_data = RV; m_dir = DR; m_mask = '0; m_edge = '0; m_rd = '0;
         for (int i = 0; i <= S; i++) samp[i] = '0;
         m_valid = 1'b1;
      end else begin
         m_sync = samp[S-1];
         m_prev = samp[S];
         case (ET)
            0:       m_det = m_sync & ~m_prev;
            1:       m_det = ~m_sync & m_prev;
            default: m_det = m_sync ^ m_prev;
         endcase
         m_wd = bus.writedata[15:0];
         case (bus.address)
            3'd0:    m_rd = {16'h0, (m_dir & m_data) | (~m_dir & m_sync)};
            3'd1:    m_rd = {16'h0, m_dir};
            3'd2:    m_rd = {16'h0, m_mask};
            3'd3:    m_rd = {16'h0, m_edge};
            default: m_rd = '0;
         endcase
         m_w1c = '0;
         if (bus.chipselect && !bus.write_n) begin
            case (bus.address)
               3'd0: m_data = m_wd;
               3'd1: m_dir  = m_wd;
               3'd2: m_mask = m_wd;
               3'd3: m_w1c  = m_wd;
`ifdef PIO_GEN_SETCLR_EN
               3'd4: m_data = m_data | m_wd;
               3'd5: m_data = m_data & ~m_wd;
`endif
               default: ;
            endcase
         end
         m_edge = (m_edge & ~m_w1c) | m_det;
         for (int i = S; i > 0; i--) samp[i] = samp[i-1];
         samp[0] = in_port;
      end
   end

   always @(negedge clk) begin
      if (reset_n && m_valid) begin
         check("readdata", bus.readdata, m_rd);
         check("out_port", 32'(out_port), 32'(m_data));
         check("oe", 32'(oe), 32'(m_dir));
         check("irq", 32'(irq), 32'(|(m_edge & m_mask)));
      end
   end

   task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [15:0] pin);
      bus.address    = a;
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.writedata  = wd;
      in_port        = pin;
      @(negedge clk);
   endtask

   initial begin
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      check("rst_out_port", 32'(out_port), 32'(RV));
      check("rst_oe", 32'(oe), 32'(DR));
      check("rst_irq", 32'(irq), 32'h0);
      for (int a = 0; a < 8; a++) begin
         cyc(3'(a), 1'b0, 1'b1, 32'h0, 16'h0000);
         check("rst_read", bus.readdata, 32'h0);
      end

      cyc(3'd1, 1'b1, 1'b0, 32'h0000_00FF, 16'h0000);
      cyc(3'd0, 1'b1, 1'b0, 32'h0000_A5C3, 16'h1200);
      check("out_port_A5C3", 32'(out_port), 32'h0000_A5C3);
      cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1200);
      cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1200);
      check("data_read_12C3", bus.readdata, 32'h0000_12C3);

      cyc(3'd3, 1'b1, 1'b0, 32'h0000_FFFF, 16'h1200);
      cyc(3'd2, 1'b1, 1'b0, 32'h0000_0001, 16'h1200);
      cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1201);
      cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1201);
      check("irq_not_early", 32'(irq), 32'h0);
      cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1201);
      check("irq_rise", 32'(irq), 32'h1);
      cyc(3'd3, 1'b0, 1'b1, 32'h0, 16'h1201);
      check("edge_read_1", bus.readdata, 32'h0000_0001);
      cyc(3'd3, 1'b1, 1'b0, 32'h0000_0001, 16'h1201);
      check("irq_w1c", 32'(irq), 32'h0);

      repeat (3) cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1200);
      check("no_fall_capture", 32'(irq), 32'h0);
      cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1201);
      cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1201);
      cyc(3'd3, 1'b1, 1'b0, 32'h0000_0001, 16'h1201);
      check("irq_set_wins", 32'(irq), 32'h1);
      cyc(3'd3, 1'b0, 1'b1, 32'h0, 16'h1201);
      check("edge_set_wins", bus.readdata, 32'h0000_0001);

      cyc(3'd0, 1'b1, 1'b0, 32'h0000_00F0, 16'h1201);
      cyc(3'd4, 1'b1, 1'b0, 32'h0000_0003, 16'h1201);
      cyc(3'd5, 1'b1, 1'b0, 32'h0000_0010, 16'h1201);
`ifdef PIO_GEN_SETCLR_EN
      check("setclr_out", 32'(out_port), 32'h0000_00E3);
`else
      check("setclr_out", 32'(out_port), 32'h0000_00F0);
`endif
      cyc(3'd4, 1'b0, 1'b1, 32'h0, 16'h1201);
      check("read_addr4", bus.readdata, 32'h0);

      cyc(3'd2, 1'b1, 1'b0, 32'h0000_0003, 16'h1201);
      repeat (3) cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1203);
      cyc(3'd3, 1'b0, 1'b1, 32'h0, 16'h1203);
      check("edge_read_3", bus.readdata, 32'h0000_0003);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_rd", bus.readdata, 32'h0);
      check("async_rst_irq", 32'(irq), 32'h0);
      check("async_rst_out", 32'(out_port), 32'(RV));
      check("async_rst_oe", 32'(oe), 32'(DR));
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) cyc(3'd0, 1'b0, 1'b1, 32'h0, 16'h1203);
      cyc(3'd3, 1'b0, 1'b1, 32'h0, 16'h1203);
      check("post_rst_edge", bus.readdata, 32'h0000_1203);
      cyc(3'd2, 1'b0, 1'b1, 32'h0, 16'h1203);
      check("post_rst_mask", bus.readdata, 32'h0);

      rp = 16'h1203;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) rp = rp ^ 16'($urandom);
         cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom), rp);
         if (n == 300) begin
            #3 reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
